// File: rtl/flash_phy_xex_seq_pkg.sv
// Shared flash phy XEX definitions: sequencer state encoding, default widths,
// default watchdog limit and the cipher op-type encoding used by the scramble
// engine.
package flash_phy_xex_seq_pkg;

  // Default data block / mask width and bank-local word address width.
  localparam int XexDataWidth     = 64;
  localparam int XexBankAddrW     = 17;

  // Default watchdog limit, in cycles, for any single engine handshake.
  localparam int XexTimeoutCycles = 256;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OP   = 2'd2,
    DONE = 2'd3
  } xex_state_e;

  // Cipher operation type as seen by the scramble engine.
  typedef enum logic {
    ScrambleOp   = 1'b0,
    DeScrambleOp = 1'b1
  } xex_op_e;

endpackage : flash_phy_xex_seq_pkg

// File: rtl/flash_phy_xex_timer.sv
// Saturating watchdog counter. clr_i has priority over en_i; expired_o is
// high while the count sits at Limit-1, where the counter stops.
module flash_phy_xex_timer #(
  parameter int Limit = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CntW = (Limit > 2) ? $clog2(Limit) : 1;

  logic [CntW-1:0] count_q;

  assign expired_o = (count_q == CntW'(Limit - 1));

  // Count enabled cycles, clear on request, hold once expired.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && !expired_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule : flash_phy_xex_timer

// File: rtl/flash_phy_xex_seq.sv
// Per-bank XEX sequencer in front of the shared flash scramble engine.
// A job is: fetch the GF address mask, pre-whiten (data ^ mask), run the
// block cipher, post-whiten (result ^ mask), return the result.
// A watchdog aborts any engine handshake that stalls for TimeoutCycles.
// Optional build macro FLASH_PHY_XEX_MASK_CACHE_EN keeps the last mask and
// its address so a repeat job to the same address skips the mask fetch.
//
// Handshakes: every *_req is held high, with its payload stable, until the
// matching *_ack is seen high on a clock edge; that edge is the transfer and
// the request drops on the following cycle. Acks are single-cycle pulses.
// ack_o and err_o are mutually exclusive one-cycle pulses ending a job.
module flash_phy_xex_seq
  import flash_phy_xex_seq_pkg::*;
#(
  parameter int DataWidth     = XexDataWidth,
  parameter int BankAddrW     = XexBankAddrW,
  parameter int TimeoutCycles = XexTimeoutCycles
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // job interface
  input  logic                 req_i,
  input  logic                 descramble_i,
  input  logic [BankAddrW-1:0] addr_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 ack_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 err_o,
  // GF mask request to the scramble engine
  output logic                 calc_req_o,
  output logic [BankAddrW-1:0] calc_addr_o,
  input  logic                 calc_ack_i,
  input  logic [DataWidth-1:0] mask_i,
  // block cipher request to the scramble engine
  output logic                 op_req_o,
  output logic                 op_type_o,
  output logic [DataWidth-1:0] op_plain_o,
  output logic [DataWidth-1:0] op_scrambled_o,
  input  logic                 op_ack_i,
  input  logic [DataWidth-1:0] op_plain_i,
  input  logic [DataWidth-1:0] op_scrambled_i,
  // debug view of the sequencer state
  output xex_state_e           state_o
);

  xex_state_e           state_q;
  xex_op_e              op_q;
  logic [DataWidth-1:0] data_q;
  logic [DataWidth-1:0] mask_q;

  logic                 calc_done;
  logic                 op_done;
  logic                 wait_phase;
  logic                 timer_expired;
  logic                 timeout;
  logic                 cache_hit;
  logic [DataWidth-1:0] whiten_calc;
  logic [DataWidth-1:0] whiten_hit;
  logic [DataWidth-1:0] result_d;

  assign state_o   = state_q;
  assign op_type_o = op_q;

  assign calc_done  = (state_q == CALC) && calc_ack_i;
  assign op_done    = (state_q == OP)   && op_ack_i;
  assign wait_phase = (state_q == CALC) || (state_q == OP);
  // An ack on the expiry cycle still completes the handshake.
  assign timeout    = wait_phase && timer_expired && !calc_done && !op_done;

  // Pre-whitening with a freshly delivered mask, or with the cached one.
  assign whiten_calc = data_q ^ mask_i;
  assign whiten_hit  = data_i ^ mask_q;
  // Post-whitening: pick the cipher output matching the direction.
  assign result_d    = ((op_q == DeScrambleOp) ? op_plain_i : op_scrambled_i) ^ mask_q;

  // Counter restarts on every state entry and only runs while waiting.
  flash_phy_xex_timer #(
    .Limit (TimeoutCycles)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (!wait_phase || calc_done || op_done || timeout),
    .en_i      (wait_phase),
    .expired_o (timer_expired)
  );

`ifdef FLASH_PHY_XEX_MASK_CACHE_EN
  logic                 cache_valid_q;
  logic [BankAddrW-1:0] cache_addr_q;

  // Remember which address mask_q belongs to; forget it on a watchdog abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
    end else if (timeout) begin
      cache_valid_q <= 1'b0;
    end else if (calc_done) begin
      cache_valid_q <= 1'b1;
      cache_addr_q  <= calc_addr_o;
    end
  end

  assign cache_hit = cache_valid_q && (cache_addr_q == addr_i);
`else
  assign cache_hit = 1'b0;
`endif

  // Sequencer FSM with registered engine requests, results and status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      op_q           <= ScrambleOp;
      data_q         <= '0;
      mask_q         <= '0;
      ack_o          <= 1'b0;
      err_o          <= 1'b0;
      data_o         <= '0;
      calc_req_o     <= 1'b0;
      calc_addr_o    <= '0;
      op_req_o       <= 1'b0;
      op_plain_o     <= '0;
      op_scrambled_o <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Job inputs are captured here only; later changes are ignored.
          if (req_i) begin
            data_q <= data_i;
            op_q   <= descramble_i ? DeScrambleOp : ScrambleOp;
            if (cache_hit) begin
              state_q        <= OP;
              op_req_o       <= 1'b1;
              op_plain_o     <= descramble_i ? '0 : whiten_hit;
              op_scrambled_o <= descramble_i ? whiten_hit : '0;
            end else begin
              state_q     <= CALC;
              calc_req_o  <= 1'b1;
              calc_addr_o <= addr_i;
            end
          end
        end
        CALC: begin
          if (calc_ack_i) begin
            state_q        <= OP;
            mask_q         <= mask_i;
            calc_req_o     <= 1'b0;
            op_req_o       <= 1'b1;
            op_plain_o     <= (op_q == DeScrambleOp) ? '0 : whiten_calc;
            op_scrambled_o <= (op_q == DeScrambleOp) ? whiten_calc : '0;
          end else if (timeout) begin
            state_q    <= IDLE;
            calc_req_o <= 1'b0;
            err_o      <= 1'b1;
          end
        end
        OP: begin
          if (op_ack_i) begin
            state_q        <= DONE;
            op_req_o       <= 1'b0;
            op_plain_o     <= '0;
            op_scrambled_o <= '0;
            data_o         <= result_d;
            ack_o          <= 1'b1;
          end else if (timeout) begin
            state_q        <= IDLE;
            op_req_o       <= 1'b0;
            op_plain_o     <= '0;
            op_scrambled_o <= '0;
            err_o          <= 1'b1;
          end
        end
        DONE: begin
          // Guarantees one idle cycle even if req_i stays high.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : flash_phy_xex_seq
